cordic_rotation_sequencer: RTL

- Iterative control stage that sits directly upstream of the single-iteration CORDIC engine PE, in rotation mode.
- Accepts an angle request and folds it into the convergence range ±π/2.
- Drives the PE once per iteration with x/y/alpha, atan(2^-i) from an internal LUT, and shift count i. It feeds the PE outputs back, and after N_PE iterations applies quadrant correction and presents cos/sin.

---
 rtl/cordic_rotation_sequencer_if.sv | 33 +++
 rtl/cordic_rotation_sequencer.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/cordic_rotation_sequencer_if.sv
// cordic_rotation_sequencer_if: request/result port and PE-facing bus of the CORDIC sequencer
interface cordic_rotation_sequencer_if #(
  parameter int DATA_WIDTH = 18,
  parameter int CW = 5
);
  logic [DATA_WIDTH-1:0] i_angle;
  logic                  i_start;
  logic                  o_ready;
  logic [DATA_WIDTH-1:0] eng_x;
  logic [DATA_WIDTH-1:0] eng_y;
  logic [DATA_WIDTH-1:0] eng_alpha;
  logic [DATA_WIDTH-1:0] eng_atan;
  logic [CW-1:0]         eng_count;
  logic                  eng_valid;
  logic [DATA_WIDTH-1:0] eng_x_r;
  logic [DATA_WIDTH-1:0] eng_y_r;
  logic [DATA_WIDTH-1:0] eng_alpha_r;
  logic                  eng_valid_r;
  logic [DATA_WIDTH-1:0] o_cos;
  logic [DATA_WIDTH-1:0] o_sin;
  logic                  o_valid;
  logic                  o_err;
  modport master (
    output i_angle, i_start, eng_x_r, eng_y_r, eng_alpha_r, eng_valid_r,
    input  o_ready, eng_x, eng_y, eng_alpha, eng_atan, eng_count, eng_valid,
           o_cos, o_sin, o_valid, o_err
  );
  modport slave (
    input  i_angle, i_start, eng_x_r, eng_y_r, eng_alpha_r, eng_valid_r,
    output o_ready, eng_x, eng_y, eng_alpha, eng_atan, eng_count, eng_valid,
           o_cos, o_sin, o_valid, o_err
  );
endinterface

// File: rtl/cordic_rotation_sequencer.sv
// cordic_rotation_sequencer: folds an angle into +-pi/2, iterates an external CORDIC PE N_PE times, fixes the quadrant.
// Optional CORDIC_SEQ_WATCHDOG_EN: abort a PE that stays silent for 4 WAIT cycles and pulse o_err.
module cordic_rotation_sequencer #(
  parameter int DATA_WIDTH = 18,
  parameter int N_PE = 16,
  parameter int K_INIT = 19898
) (
  input logic i_clk,
  input logic i_rst_n,
  cordic_rotation_sequencer_if.slave bus
);
  localparam int CW = $clog2(N_PE) + 1;
  localparam logic signed [DATA_WIDTH-1:0] PI = DATA_WIDTH'(102944);
  localparam logic signed [DATA_WIDTH-1:0] HPI = DATA_WIDTH'(51472);
  localparam logic [16:0] ATAN [16] = '{
    17'd25736, 17'd15193, 17'd8027, 17'd4075, 17'd2045, 17'd1024, 17'd512, 17'd256,
    17'd128, 17'd64, 17'd32, 17'd16, 17'd8, 17'd4, 17'd2, 17'd1
  };
  typedef enum logic [2:0] {S_IDLE, S_FOLD, S_ISSUE, S_WAIT, S_DONE} state_t;
  state_t state_q, state_d;
  logic signed [DATA_WIDTH-1:0] angle_q, angle_d;
  logic [DATA_WIDTH-1:0] x_q, x_d, y_q, y_d, alpha_q, alpha_d, atan_q, atan_d;
  logic [DATA_WIDTH-1:0] cos_q, cos_d, sin_q, sin_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic neg_q, neg_d, valid_q, valid_d;
`ifdef CORDIC_SEQ_WATCHDOG_EN
  logic [2:0] wd_q, wd_d;
  logic err_q, err_d;
`endif
  // entries past the table (i >= 16) read as zero
  function automatic logic [DATA_WIDTH-1:0] lut(input logic [4:0] i);
    return i[4] ? '0 : DATA_WIDTH'(ATAN[i[3:0]]);
  endfunction
  assign cnt_inc = cnt_q + CW'(1);
  assign bus.o_ready = state_q == S_IDLE;
  assign bus.eng_valid = state_q == S_ISSUE;
  assign bus.eng_x = x_q;
  assign bus.eng_y = y_q;
  assign bus.eng_alpha = alpha_q;
  assign bus.eng_atan = atan_q;
  assign bus.eng_count = cnt_q;
  assign bus.o_cos = cos_q;
  assign bus.o_sin = sin_q;
  assign bus.o_valid = valid_q;
`ifdef CORDIC_SEQ_WATCHDOG_EN
  assign bus.o_err = err_q;
`else
  assign bus.o_err = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    angle_d = angle_q;
    x_d = x_q;
    y_d = y_q;
    alpha_d = alpha_q;
    atan_d = atan_q;
    cnt_d = cnt_q;
    neg_d = neg_q;
    cos_d = cos_q;
    sin_d = sin_q;
    valid_d = 1'b0;
`ifdef CORDIC_SEQ_WATCHDOG_EN
    wd_d = wd_q;
    err_d = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.i_start) begin
          angle_d = bus.i_angle;
          state_d = S_FOLD;
        end
      end
      S_FOLD: begin
        x_d = DATA_WIDTH'(K_INIT);
        y_d = '0;
        cnt_d = '0;
        atan_d = lut(5'd0);
        neg_d = (angle_q > HPI) || (angle_q < -HPI);
        alpha_d = angle_q > HPI ? angle_q - PI : angle_q < -HPI ? angle_q + PI : angle_q;
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
`ifdef CORDIC_SEQ_WATCHDOG_EN
        wd_d = '0;
`endif
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (bus.eng_valid_r) begin
          x_d = bus.eng_x_r;
          y_d = bus.eng_y_r;
          alpha_d = bus.eng_alpha_r;
          cnt_d = cnt_inc;
          atan_d = lut(5'(cnt_inc));
          state_d = cnt_inc == CW'(N_PE) ? S_DONE : S_ISSUE;
        end
`ifdef CORDIC_SEQ_WATCHDOG_EN
        else if (wd_q == 3'd3) begin
          err_d = 1'b1;
          state_d = S_IDLE;
        end else begin
          wd_d = wd_q + 3'd1;
        end
`endif
      end
      S_DONE: begin
        cos_d = neg_q ? -x_q : x_q;
        sin_d = neg_q ? -y_q : y_q;
        valid_d = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      angle_q <= '0;
      x_q <= '0;
      y_q <= '0;
      alpha_q <= '0;
      atan_q <= '0;
      cnt_q <= '0;
      neg_q <= 1'b0;
      cos_q <= '0;
      sin_q <= '0;
      valid_q <= 1'b0;
`ifdef CORDIC_SEQ_WATCHDOG_EN
      wd_q <= '0;
      err_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      angle_q <= angle_d;
      x_q <= x_d;
      y_q <= y_d;
      alpha_q <= alpha_d;
      atan_q <= atan_d;
      cnt_q <= cnt_d;
      neg_q <= neg_d;
      cos_q <= cos_d;
      sin_q <= sin_d;
      valid_q <= valid_d;
`ifdef CORDIC_SEQ_WATCHDOG_EN
      wd_q <= wd_d;
      err_q <= err_d;
`endif
    end
  end
endmodule
